dmem_access_unit: RTL and testbench

- Data-memory access stage directly downstream of the mips core's memory outputs (ALU address, store data, memwrite).
- Registers one load/store request from the core and holds the core with `stall` until the request completes.
- Drives a synchronous block RAM with configurable read latency, byte-lane write enables and replicated store data.
- Returns sign- or zero-extended load data; misaligned or illegal accesses are flagged instead of issued.

---
 rtl/dmem_access_unit_if.sv | 34 +++
 rtl/dmem_access_unit.sv | 197 +++++++++++++++++++
 tb/tb_dmem_access_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Core-side bundle of the data-memory access unit.
//   req_valid    : core presents a memory operation
//   req_we       : 1 = store, 0 = load
//   req_size     : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr     : byte address from the core ALU
//   req_wdata    : right-justified store data
//   stall        : hold the core pipeline/PC
//   rdata        : extended load result
//   rdata_valid  : one-cycle pulse, load completed
//   addr_err     : one-cycle pulse, misaligned or illegal request
// The master modport is the core; the slave modport is the access unit.
interface dmem_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  stall, rdata, rdata_valid, addr_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output stall, rdata, rdata_valid, addr_err
  );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access stage between the core's memory outputs and a
// synchronous block RAM. One request is captured in IDLE, issued for one
// cycle in ACCESS, load data is collected in WAIT after RD_LAT cycles, and
// DONE releases the core for exactly one cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   core          : core-side request/response bundle (dmem_if.slave)
//   ram_en        : RAM access strobe (one cycle per access)
//   ram_wea       : RAM byte write enables
//   ram_addr      : RAM word address (byte address bits ADDR_W+1:2)
//   ram_wdata     : lane-replicated store data
//   ram_rdata     : RAM read data, valid RD_LAT cycles after ram_en
// Parameters: ADDR_W word-address width, RD_LAT read latency (1..4).
module dmem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_if.slave             core,
  output logic              ram_en,
  output logic [3:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [1:0]        lane_q, lane_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rdata_valid_q, rdata_valid_d;
  logic              addr_err_q, addr_err_d;
  logic              ram_en_q, ram_en_d;
  logic [3:0]        ram_wea_q, ram_wea_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wdata_q, ram_wdata_d;

  logic              misaligned;
  logic [3:0]        lane_mask;
  logic [31:0]       repl_wdata;
  logic [31:0]       load_ext;
  logic [7:0]        rd_byte [4];
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // Address bits above the RAM word address are intentionally ignored.
  logic              addr_hi_unused;
  assign addr_hi_unused = ^core.req_addr[31:ADDR_W+2];

  assign misaligned = (core.req_size == 2'b11) ||
                      (core.req_size == 2'b01 && core.req_addr[0]) ||
                      (core.req_size == 2'b10 && core.req_addr[1:0] != 2'b00);

  // Store lane mask and data replication so the RAM needs no byte steering.
  always_comb begin
    lane_mask  = 4'b1111;
    repl_wdata = core.req_wdata;
    case (core.req_size)
      2'b00: begin
        lane_mask  = 4'b0001 << core.req_addr[1:0];
        repl_wdata = {4{core.req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask  = core.req_addr[1] ? 4'b1100 : 4'b0011;
        repl_wdata = {2{core.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rd_byte
      assign rd_byte[gi] = ram_rdata[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = rd_byte[lane_q];
  assign half_sel = lane_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

  always_comb begin
    load_ext = ram_rdata;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    rdata_d       = rdata_q;
    rdata_valid_d = 1'b0;
    addr_err_d    = 1'b0;
    ram_en_d      = 1'b0;
    ram_wea_d     = 4'b0000;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (core.req_valid) begin
          if (misaligned) begin
            state_d    = S_DONE;
            addr_err_d = 1'b1;
          end else begin
            // RAM outputs are registered, so they are set up here and
            // appear on the pins during ACCESS.
            state_d     = S_ACCESS;
            we_d        = core.req_we;
            size_d      = core.req_size;
            uns_d       = core.req_unsigned;
            lane_d      = core.req_addr[1:0];
            ram_en_d    = 1'b1;
            ram_wea_d   = core.req_we ? lane_mask : 4'b0000;
            ram_addr_d  = core.req_addr[ADDR_W+1:2];
            ram_wdata_d = repl_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d       = S_DONE;
          rdata_d       = load_ext;
          rdata_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      lane_q        <= 2'b00;
      cnt_q         <= 2'd0;
      rdata_q       <= 32'd0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_wea_q     <= 4'b0000;
      ram_addr_q    <= '0;
      ram_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      addr_err_q    <= addr_err_d;
      ram_en_q      <= ram_en_d;
      ram_wea_q     <= ram_wea_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
    end
  end

  // Combinational so the core is held in the very cycle a request appears.
  assign core.stall       = core.req_valid & (state_q != S_DONE);
  assign core.rdata       = rdata_q;
  assign core.rdata_valid = rdata_valid_q;
  assign core.addr_err    = addr_err_q;
  assign ram_en           = ram_en_q;
  assign ram_wea          = ram_wea_q;
  assign ram_addr         = ram_addr_q;
  assign ram_wdata        = ram_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
module tb_dmem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, mem_clr, sel;
  logic        rv, we, uns;
  logic [1:0]  sz;
  logic [31:0] addr, wd;
  int          checks = 0, passes = 0, fails = 0;

  dmem_if c1 ();
  dmem_if c3 ();
  assign c1.req_valid = rv & ~sel;
  assign c3.req_valid = rv & sel;
  assign c1.req_we = we;        assign c3.req_we = we;
  assign c1.req_size = sz;      assign c3.req_size = sz;
  assign c1.req_unsigned = uns; assign c3.req_unsigned = uns;
  assign c1.req_addr = addr;    assign c3.req_addr = addr;
  assign c1.req_wdata = wd;     assign c3.req_wdata = wd;

  logic        en1, en3;
  logic [3:0]  wea1, wea3;
  logic [9:0]  ad1, ad3;
  logic [31:0] wdat1, wdat3, rd1, rd3;

  dmem_access_unit #(.ADDR_W(10), .RD_LAT(1)) u1 (
    .clk(clk), .rst(rst), .core(c1.slave), .ram_en(en1), .ram_wea(wea1),
    .ram_addr(ad1), .ram_wdata(wdat1), .ram_rdata(rd1));
  dmem_access_unit #(.ADDR_W(10), .RD_LAT(3)) u3 (
    .clk(clk), .rst(rst), .core(c3.slave), .ram_en(en3), .ram_wea(wea3),
    .ram_addr(ad3), .ram_wdata(wdat3), .ram_rdata(rd3));

  // RAM stubs: data is only present exactly RD_LAT cycles after ram_en.
  logic [31:0] m1 [1024];
  logic [31:0] m3 [1024];
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) m1[i] <= 32'd0;
    end else if (en1) begin
      for (int b = 0; b < 4; b++) if (wea1[b]) m1[ad1][8*b +: 8] <= wdat1[8*b +: 8];
    end
    p1 <= (en1 && !mem_clr) ? m1[ad1] : 32'hBAD0BAD0;
  end
  assign rd1 = p1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) m3[i] <= 32'd0;
    end else if (en3) begin
      for (int b = 0; b < 4; b++) if (wea3[b]) m3[ad3][8*b +: 8] <= wdat3[8*b +: 8];
    end
    p3[0] <= (en3 && !mem_clr) ? m3[ad3] : 32'hBAD0BAD0;
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd3 = p3[2];

  // Observed outputs of the currently selected DUT.
  logic        o_stall, o_rvalid, o_err, o_en;
  logic [31:0] o_rdata, o_wdata;
  logic [3:0]  o_wea;
  logic [9:0]  o_addr;
  assign o_stall  = sel ? c3.stall : c1.stall;
  assign o_rvalid = sel ? c3.rdata_valid : c1.rdata_valid;
  assign o_err    = sel ? c3.addr_err : c1.addr_err;
  assign o_rdata  = sel ? c3.rdata : c1.rdata;
  assign o_en     = sel ? en3 : en1;
  assign o_wea    = sel ? wea3 : wea1;
  assign o_addr   = sel ? ad3 : ad1;
  assign o_wdata  = sel ? wdat3 : wdat1;

  // Reference model: byte-addressed memory and last load result per DUT.
  logic [7:0]  rb [2][4096];
  logic [31:0] exp_r [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdata"}, o_rdata, 32'd0);
    check({tag, "_rvalid"}, {31'd0, o_rvalid}, 32'd0);
    check({tag, "_err"}, {31'd0, o_err}, 32'd0);
    check({tag, "_en"}, {31'd0, o_en}, 32'd0);
    check({tag, "_wea"}, {28'd0, o_wea}, 32'd0);
    check({tag, "_addr"}, {22'd0, o_addr}, 32'd0);
    check({tag, "_wdata"}, o_wdata, 32'd0);
  endtask

  // One complete transaction with cycle-by-cycle expectations.
  task automatic op(input bit s, input bit w, input logic [1:0] size, input bit u,
                    input logic [31:0] a, input logic [31:0] d, input bit drop2);
    int  si = s ? 1 : 0;
    int  lat = s ? 3 : 1;
    int  ba = int'(a[11:0]);
    int  nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    bit  err = (size == 2'd3) || (size == 2'd1 && a[0]) || (size == 2'd2 && a[1:0] != 2'd0);
    int  done = err ? 1 : (w ? 2 : 2 + lat);
    logic [31:0] v = 0, exp_wea = 0, exp_wd;
    if (!err && !w) begin
      for (int i = 0; i < nb; i++) v = v + (32'(rb[si][ba + i]) << (8 * i));
      if (!u && nb == 1 && v >= 128) v = v - 256;
      if (!u && nb == 2 && v >= 32768) v = v - 65536;
      exp_r[si] = v;
    end
    for (int i = 0; i < nb; i++) exp_wea = exp_wea | (32'd1 << ((ba % 4) + i));
    exp_wd = (nb == 1) ? (d & 32'hFF) * 32'h01010101 :
             (nb == 2) ? (d & 32'hFFFF) * 32'h00010001 : d;
    if (!err && w) for (int i = 0; i < nb; i++) rb[si][ba + i] = 8'((d >> (8 * i)) & 32'hFF);

    @(posedge clk); #1;
    sel = s; we = w; sz = size; uns = u; addr = a; wd = d; rv = 1'b1;
    #1 check("stall_c0", {31'd0, o_stall}, 32'd1);
    for (int cyc = 1; cyc <= done; cyc++) begin
      @(posedge clk); #1;
      if (drop2 && cyc == 2) rv = 1'b0;
      #1;
      check($sformatf("en_c%0d", cyc), {31'd0, o_en}, {31'd0, (cyc == 1 && !err)});
      check($sformatf("stall_c%0d", cyc), {31'd0, o_stall}, {31'd0, (rv && cyc != done)});
      if (cyc == 1 && !err) begin
        check("ram_addr", {22'd0, o_addr}, 32'(a[11:2]));
        check("ram_wea", {28'd0, o_wea}, w ? exp_wea : 32'd0);
        if (w) check("ram_wdata", o_wdata, exp_wd);
      end
      if (cyc < done) begin
        check($sformatf("rvalid_c%0d", cyc), {31'd0, o_rvalid}, 32'd0);
        check($sformatf("err_c%0d", cyc), {31'd0, o_err}, 32'd0);
      end else begin
        check("rvalid_done", {31'd0, o_rvalid}, {31'd0, (!w && !err)});
        check("err_done", {31'd0, o_err}, {31'd0, err});
        check("rdata_done", o_rdata, exp_r[si]);
      end
    end
    rv = 1'b0;
    $display("op dut=%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h err=%0d rdata=%h",
             s ? 3 : 1, w, size, u, a, d, err, o_rdata);
  endtask

  initial begin
    rst = 1'b1; mem_clr = 1'b1; sel = 1'b0;
    rv = 1'b0; we = 1'b0; uns = 1'b0; sz = 2'd0; addr = 32'd0; wd = 32'd0;
    for (int k = 0; k < 2; k++) begin
      exp_r[k] = 32'd0;
      for (int i = 0; i < 4096; i++) rb[k][i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("rst1");
    sel = 1'b1;
    #1 check_idle_outputs("rst3");
    check("rst3_stall", {31'd0, o_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_clr = 1'b0; sel = 1'b0;

    // RD_LAT=1 directed cases
    op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
    op(0, 0, 2'd2, 0, 32'h10, 32'h0, 0);
    op(0, 1, 2'd0, 0, 32'h13, 32'h00000080, 0);
    op(0, 0, 2'd0, 0, 32'h13, 32'h0, 0);
    op(0, 0, 2'd0, 1, 32'h13, 32'h0, 0);
    op(0, 1, 2'd1, 0, 32'h22, 32'h00008001, 0);
    op(0, 0, 2'd1, 0, 32'h22, 32'h0, 0);
    op(0, 0, 2'd1, 1, 32'h22, 32'h0, 0);
    op(0, 0, 2'd2, 0, 32'h11, 32'h0, 0);
    op(0, 0, 2'd3, 0, 32'h20, 32'h0, 0);
    op(0, 1, 2'd1, 0, 32'h21, 32'h5555, 0);

    // RD_LAT=3, including req_valid dropped mid-operation
    op(1, 1, 2'd2, 0, 32'h40, 32'h12345678, 0);
    op(1, 0, 2'd2, 0, 32'h40, 32'h0, 1);
    op(1, 0, 2'd0, 0, 32'h43, 32'h0, 0);

    // Reset during WAIT aborts the load
    @(posedge clk); #1;
    sel = 1'b1; we = 1'b0; sz = 2'd2; uns = 1'b0; addr = 32'h40; rv = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rv = 1'b0;
    exp_r[0] = 32'd0; exp_r[1] = 32'd0;
    #1 check_idle_outputs("midrst");
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check("midrst_rvalid", {31'd0, o_rvalid}, 32'd0);
      check("midrst_en", {31'd0, o_en}, 32'd0);
    end
    $display("op dut=3 reset during WAIT");
    op(1, 0, 2'd2, 0, 32'h40, 32'h0, 0);

    // Randomized mix across both latencies
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ra = $urandom_range(0, 255);
      logic [1:0]  rs = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      op(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), rs,
         bit'($urandom_range(0, 1)), ra, $urandom, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
